// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one line-wide backing memory (datamem) between the instruction
// cache (port I) and the data cache (port D). Exactly one transaction is in
// flight at a time. The sequence is IDLE -> ISSUE -> RESP -> IDLE. The
// grant is registered, and every output comes straight from a flop.
//
// Arbitration:
//   default                  round-robin. A lone requester wins. When both
//                            request, the port that was not granted last
//                            wins. After reset, I wins the first tie.
//   MEM_ARB_DPRIO_EN defined fixed priority. D wins every tie. I can starve
//                            while D keeps requesting back-to-back.
//
// Parameters:
//   ADDR_WIDTH  byte address width
//   LINE_WIDTH  cache-line width
//   TIMEOUT     maximum ISSUE cycles spent waiting for mem_ready.
//               0 disables the watchdog.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/d_req              request, held until own *_ready
//   i_we/d_we                1 = line write, 0 = line read
//   i_addr/d_addr            line address
//   i_wdata/d_wdata          write line
//   i_rdata/d_rdata          read line, valid with *_ready, held until
//                            the next grant to the same port
//   i_ready/d_ready          one-cycle completion pulse
//   i_err/d_err              one-cycle pulse with *_ready on a timeout
//   mem_req, WriteEnable     request and write strobe to datamem
//   memory_address           address to datamem
//   mem_writedata            write line to datamem
//   mem_readdata, mem_ready  read line and completion from datamem
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [LINE_WIDTH-1:0] mem_writedata,
    input  logic [LINE_WIDTH-1:0] mem_readdata,
    input  logic                  mem_ready
);

    // The watchdog is wide enough to hold TIMEOUT, clamped to 8..32 bits.
    localparam int WDOG_RAW  = $clog2(TIMEOUT + 1);
    localparam int WDOG_BITS = (WDOG_RAW < 8) ? 8 : ((WDOG_RAW > 32) ? 32 : WDOG_RAW);
    localparam logic [WDOG_BITS-1:0] TIMEOUT_CNT = WDOG_BITS'(TIMEOUT);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arbState;

    arbState stateReg, stateNext;

    // Grant encoding: 0 = port I, 1 = port D.
    logic                  gntReg, gntNext;
    logic                  lastGrantReg, lastGrantNext;
    logic                  weReg, weNext;
    logic [ADDR_WIDTH-1:0] addrReg, addrNext;
    logic [LINE_WIDTH-1:0] wdataReg, wdataNext;
    logic [LINE_WIDTH-1:0] iRdataReg, iRdataNext;
    logic [LINE_WIDTH-1:0] dRdataReg, dRdataNext;
    logic [WDOG_BITS-1:0]  wdogReg, wdogNext;
    logic                  memReqReg, memReqNext;
    logic                  writeEnReg, writeEnNext;
    logic                  iReadyReg, iReadyNext;
    logic                  dReadyReg, dReadyNext;
    logic                  iErrReg, iErrNext;
    logic                  dErrReg, dErrNext;
    logic                  pickD;

    // Winner selection. It is only used when IDLE sees at least one request.
`ifdef MEM_ARB_DPRIO_EN
    assign pickD = d_req;
`else
    assign pickD = d_req && (!i_req || !lastGrantReg);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            gntReg       <= 1'b0;
            lastGrantReg <= 1'b1;
            weReg        <= 1'b0;
            addrReg      <= '0;
            wdataReg     <= '0;
            iRdataReg    <= '0;
            dRdataReg    <= '0;
            wdogReg      <= '0;
            memReqReg    <= 1'b0;
            writeEnReg   <= 1'b0;
            iReadyReg    <= 1'b0;
            dReadyReg    <= 1'b0;
            iErrReg      <= 1'b0;
            dErrReg      <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            gntReg       <= gntNext;
            lastGrantReg <= lastGrantNext;
            weReg        <= weNext;
            addrReg      <= addrNext;
            wdataReg     <= wdataNext;
            iRdataReg    <= iRdataNext;
            dRdataReg    <= dRdataNext;
            wdogReg      <= wdogNext;
            memReqReg    <= memReqNext;
            writeEnReg   <= writeEnNext;
            iReadyReg    <= iReadyNext;
            dReadyReg    <= dReadyNext;
            iErrReg      <= iErrNext;
            dErrReg      <= dErrNext;
        end
    end

    // Each output flop is loaded with the value that matches the state being
    // entered. The outputs are therefore aligned with stateReg, yet no input
    // reaches an output through combinational logic.
    always_comb begin
        stateNext     = stateReg;
        gntNext       = gntReg;
        lastGrantNext = lastGrantReg;
        weNext        = weReg;
        addrNext      = addrReg;
        wdataNext     = wdataReg;
        iRdataNext    = iRdataReg;
        dRdataNext    = dRdataReg;
        wdogNext      = wdogReg;
        memReqNext    = 1'b0;
        writeEnNext   = 1'b0;
        iReadyNext    = 1'b0;
        dReadyNext    = 1'b0;
        iErrNext      = 1'b0;
        dErrNext      = 1'b0;

        case (stateReg)
            IDLE: begin
                if (i_req || d_req) begin
                    gntNext     = pickD;
                    weNext      = pickD ? d_we    : i_we;
                    addrNext    = pickD ? d_addr  : i_addr;
                    wdataNext   = pickD ? d_wdata : i_wdata;
                    wdogNext    = '0;
                    memReqNext  = 1'b1;
                    writeEnNext = pickD ? d_we : i_we;
                    stateNext   = ISSUE;
                end
            end

            ISSUE: begin
                memReqNext  = 1'b1;
                writeEnNext = weReg;
                if (wdogReg != '1) begin
                    wdogNext = wdogReg + 1'b1;
                end
                if (mem_ready) begin
                    // A write also captures the read bus. The requester
                    // ignores rdata on writes.
                    if (gntReg) begin
                        dRdataNext = mem_readdata;
                    end else begin
                        iRdataNext = mem_readdata;
                    end
                    memReqNext  = 1'b0;
                    writeEnNext = 1'b0;
                    iReadyNext  = !gntReg;
                    dReadyNext  = gntReg;
                    stateNext   = RESP;
                end else if (WDOG_EN && (wdogReg == TIMEOUT_CNT)) begin
                    if (gntReg) begin
                        dRdataNext = '0;
                    end else begin
                        iRdataNext = '0;
                    end
                    memReqNext  = 1'b0;
                    writeEnNext = 1'b0;
                    iReadyNext  = !gntReg;
                    dReadyNext  = gntReg;
                    iErrNext    = !gntReg;
                    dErrNext    = gntReg;
                    stateNext   = RESP;
                end
            end

            RESP: begin
                // The return to IDLE gives a one-cycle bubble. The served
                // requester uses it to drop req before arbitration runs again.
                lastGrantNext = gntReg;
                stateNext     = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign mem_req        = memReqReg;
    assign WriteEnable    = writeEnReg;
    assign memory_address = addrReg;
    assign mem_writedata  = wdataReg;
    assign i_rdata        = iRdataReg;
    assign d_rdata        = dRdataReg;
    assign i_ready        = iReadyReg;
    assign d_ready        = dReadyReg;
    assign i_err          = iErrReg;
    assign d_err          = dErrReg;

endmodule
